// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU opcodes, forwarding selects and EX/MEM control bundle.
package ex_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage.
interface ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);

    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [3:0]            alu_control;
    logic                  alu_src;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic [DATA_W-1:0]     memwb_data;
    logic                  out_valid;
    logic [DATA_W-1:0]     alu_result;
    logic                  zero;
    logic                  overflow;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic [31:0]           op_count;

    modport master (
        output in_valid, stall, flush, alu_control, alu_src, rs_data, rt_data, imm,
               rd_addr, reg_write, mem_read, mem_write, forward_a, forward_b, memwb_data,
        input  out_valid, alu_result, zero, overflow, store_data, out_rd_addr,
               out_reg_write, out_mem_read, out_mem_write, op_count
    );

    modport slave (
        input  in_valid, stall, flush, alu_control, alu_src, rs_data, rt_data, imm,
               rd_addr, reg_write, mem_read, mem_write, forward_a, forward_b, memwb_data,
        output out_valid, alu_result, zero, overflow, store_data, out_rd_addr,
               out_reg_write, out_mem_read, out_mem_write, op_count
    );

endinterface

// File: rtl/ex_stage_alu_core.sv
// alu_core: combinational add/sub/and/or with zero and signed-overflow flags.
module alu_core
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              ovf_add;
    logic              ovf_sub;

    always_comb begin
        sum      = a + b;
        diff     = a - b;
        ovf_add  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        ovf_sub  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        result   = alu_control == ALU_ADD ? sum :
                   alu_control == ALU_SUB ? diff :
                   alu_control == ALU_AND ? (a & b) :
                   alu_control == ALU_OR  ? (a | b) : '0;
        overflow = alu_control == ALU_ADD ? ovf_add :
                   alu_control == ALU_SUB ? ovf_sub : 1'b0;
        zero     = result == '0;
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding muxes, ALU and EX/MEM register with retired-op counter.
// Define EX_FORWARD_EN to enable forwarding; otherwise operands come straight from the register file.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic     clk,
    input logic     rst,
    ex_stage_if.slave bus
);

    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     fwd_b;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_zero;
    logic                  alu_ovf;

    logic                  valid_q,  valid_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic                  zero_q,   zero_d;
    logic                  ovf_q,    ovf_d;
    logic [DATA_W-1:0]     store_q,  store_d;
    logic [REG_ADDR_W-1:0] rd_q,     rd_d;
    ctrl_t                 ctrl_q,   ctrl_d;
    logic [31:0]           count_q,  count_d;

`ifdef EX_FORWARD_EN
    // EX/MEM source is the registered result, so dependent back-to-back ops need no bubble.
    always_comb begin
        op_a  = bus.forward_a == FWD_MEMWB ? bus.memwb_data :
                bus.forward_a == FWD_EXMEM ? result_q : bus.rs_data;
        fwd_b = bus.forward_b == FWD_MEMWB ? bus.memwb_data :
                bus.forward_b == FWD_EXMEM ? result_q : bus.rt_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.forward_a, bus.forward_b, bus.memwb_data};
    assign op_a  = bus.rs_data;
    assign fwd_b = bus.rt_data;
`endif

    assign op_b = bus.alu_src ? bus.imm : fwd_b;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a           (op_a),
        .b           (op_b),
        .alu_control (bus.alu_control),
        .result      (alu_res),
        .zero        (alu_zero),
        .overflow    (alu_ovf)
    );

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        store_d  = store_q;
        rd_d     = rd_q;
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!bus.stall) begin
            valid_d  = bus.in_valid;
            result_d = alu_res;
            zero_d   = alu_zero;
            ovf_d    = alu_ovf;
            store_d  = fwd_b;
            rd_d     = bus.rd_addr;
            ctrl_d   = bus.in_valid ? ctrl_t'{bus.reg_write, bus.mem_read, bus.mem_write} : '0;
            count_d  = count_q + 32'(bus.in_valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            store_q  <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.alu_result    = result_q;
    assign bus.zero          = zero_q;
    assign bus.overflow      = ovf_q;
    assign bus.store_data    = store_q;
    assign bus.out_rd_addr   = rd_q;
    assign bus.out_reg_write = ctrl_q.reg_write;
    assign bus.out_mem_read  = ctrl_q.mem_read;
    assign bus.out_mem_write = ctrl_q.mem_write;
    assign bus.op_count      = count_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed expectations queued to a monitor.
module tb_ex_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] cnt;
    } out_t;

`ifdef EX_FORWARD_EN
    localparam logic [31:0] EXMEM_RES = 32'd8;
    localparam logic [31:0] MEMWB_RES = 32'h101;
    localparam logic [31:0] MEMWB_ST  = 32'h100;
`else
    localparam logic [31:0] EXMEM_RES = 32'd1;
    localparam logic [31:0] MEMWB_RES = 32'd3;
    localparam logic [31:0] MEMWB_ST  = 32'd2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    out_t  exp_q[$];
    string name_q[$];

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic v, input logic [31:0] res, input logic z, o,
                                input logic [31:0] st, input logic [4:0] rd,
                                input logic rw, mr, mw, input logic [31:0] cnt);
        return '{v, res, z, o, st, rd, rw, mr, mw, cnt};
    endfunction

    task automatic apply(input string nm, input logic v, stl, fl, input logic [3:0] op,
                         input logic src, input logic [31:0] rs, rt, im, input logic [4:0] rd,
                         input logic rw, mr, mw, input logic [1:0] fa, fb,
                         input logic [31:0] mwb, input out_t e);
        @(negedge clk);
        rst             = 1'b0;
        bus.in_valid    = v;
        bus.stall       = stl;
        bus.flush       = fl;
        bus.alu_control = op;
        bus.alu_src     = src;
        bus.rs_data     = rs;
        bus.rt_data     = rt;
        bus.imm         = im;
        bus.rd_addr     = rd;
        bus.reg_write   = rw;
        bus.mem_read    = mr;
        bus.mem_write   = mw;
        bus.forward_a   = fa;
        bus.forward_b   = fb;
        bus.memwb_data  = mwb;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic reset_check(input string nm);
        @(negedge clk);
        exp_q.push_back('0);
        name_q.push_back(nm);
        #2 rst = 1'b1;
    endtask

    initial begin
        out_t  got;
        out_t  e;
        string nm;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = '{bus.out_valid, bus.alu_result, bus.zero, bus.overflow, bus.store_data,
                        bus.out_rd_addr, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write,
                        bus.op_count};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got v=%b res=%h z=%b o=%b st=%h rd=%0d ctl=%b%b%b cnt=%h | exp v=%b res=%h z=%b o=%b st=%h rd=%0d ctl=%b%b%b cnt=%h",
                             nm, got.v, got.res, got.z, got.o, got.st, got.rd, got.rw, got.mr, got.mw, got.cnt,
                             e.v, e.res, e.z, e.o, e.st, e.rd, e.rw, e.mr, e.mw, e.cnt);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.alu_control = 4'd0;
        bus.alu_src = 1'b0; bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0; bus.rd_addr = '0;
        bus.reg_write = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.forward_a = 2'b00; bus.forward_b = 2'b00; bus.memwb_data = '0;
        reset_check("reset");
        //     name         v  stl fl op    src rs            rt            imm           rd  rw mr mw fa     fb     memwb
        apply("add",        1, 0, 0, 4'd0, 0, 32'd3,        32'd4,        32'd0,        5,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd7, 0, 0, 32'd4, 5, 1, 0, 0, 32'd1));
        apply("fwd_exmem",  1, 0, 0, 4'd0, 1, 32'd0,        32'd9,        32'd1,        6,  1, 0, 0, 2'b10, 2'b00, 32'hDEAD0000,
              mk(1, EXMEM_RES, 0, 0, 32'd9, 6, 1, 0, 0, 32'd2));
        apply("sub_ovf",    1, 0, 0, 4'd1, 0, 32'h80000000, 32'd1,        32'd0,        7,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'h7FFFFFFF, 0, 1, 32'd1, 7, 1, 0, 0, 32'd3));
        apply("and_imm",    1, 0, 0, 4'd4, 1, 32'hF0F0F0F0, 32'h12345678, 32'h0F0F0F0F, 8,  0, 0, 1, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd0, 1, 0, 32'h12345678, 8, 0, 0, 1, 32'd4));
        apply("or",         1, 0, 0, 4'd5, 0, 32'h00FF0000, 32'h0000FF00, 32'd0,        9,  1, 1, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'h00FFFF00, 0, 0, 32'h0000FF00, 9, 1, 1, 0, 32'd5));
        apply("fwd_memwb",  1, 0, 0, 4'd0, 0, 32'd1,        32'd2,        32'd0,        10, 1, 0, 0, 2'b00, 2'b01, 32'h100,
              mk(1, MEMWB_RES, 0, 0, MEMWB_ST, 10, 1, 0, 0, 32'd6));
        apply("add_ovf",    1, 0, 0, 4'd0, 0, 32'h7FFFFFFF, 32'd1,        32'd0,        11, 1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'h80000000, 0, 1, 32'd1, 11, 1, 0, 0, 32'd7));
        apply("unused_op",  1, 0, 0, 4'd2, 0, 32'd5,        32'd6,        32'd0,        12, 1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd0, 1, 0, 32'd6, 12, 1, 0, 0, 32'd8));
        apply("bubble",     0, 0, 0, 4'd0, 0, 32'd1,        32'd2,        32'd0,        13, 1, 1, 1, 2'b00, 2'b00, 32'hDEAD0000,
              mk(0, 32'd3, 0, 0, 32'd2, 13, 0, 0, 0, 32'd8));
        apply("cap_sub",    1, 0, 0, 4'd1, 0, 32'd10,       32'd3,        32'd0,        14, 1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd7, 0, 0, 32'd3, 14, 1, 0, 0, 32'd9));
        for (int i = 0; i < 3; i++)
            apply("stall",  1, 1, 0, 4'd0, 0, 32'd100 + i,  32'd200,      32'd0,        20, 0, 1, 1, 2'b00, 2'b00, 32'hDEAD0000,
                  mk(1, 32'd7, 0, 0, 32'd3, 14, 1, 0, 0, 32'd9));
        apply("flush_stall",1, 1, 1, 4'd0, 0, 32'd50,       32'd60,       32'd0,        21, 1, 1, 1, 2'b00, 2'b00, 32'hDEAD0000,
              mk(0, 32'd7, 0, 0, 32'd3, 14, 0, 0, 0, 32'd9));
        apply("flush",      1, 0, 1, 4'd0, 0, 32'd50,       32'd60,       32'd0,        21, 1, 1, 1, 2'b00, 2'b00, 32'hDEAD0000,
              mk(0, 32'd7, 0, 0, 32'd3, 14, 0, 0, 0, 32'd9));
        apply("sub_zero",   1, 0, 0, 4'd1, 0, 32'd5,        32'd5,        32'd0,        1,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd0, 1, 0, 32'd5, 1, 1, 0, 0, 32'd10));
        bus.in_valid = 1'b1;
        reset_check("reset_mid");
        apply("post_reset", 1, 0, 0, 4'd0, 0, 32'd1,        32'd1,        32'd0,        2,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd2, 0, 0, 32'd1, 2, 1, 0, 0, 32'd1));
        apply("wrap_bubble",0, 0, 0, 4'd0, 0, 32'd4,        32'd4,        32'd0,        3,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(0, 32'd8, 0, 0, 32'd4, 3, 0, 0, 0, 32'hFFFFFFFF));
        force dut.count_q = 32'hFFFFFFFF;
        #1 release dut.count_q;
        apply("wrap",       1, 0, 0, 4'd0, 0, 32'd0,        32'd0,        32'd0,        4,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(1, 32'd0, 1, 0, 32'd0, 4, 1, 0, 0, 32'd0));
        apply("post_wrap",  0, 0, 0, 4'd5, 0, 32'd1,        32'd2,        32'd0,        5,  1, 0, 0, 2'b00, 2'b00, 32'hDEAD0000,
              mk(0, 32'd3, 0, 0, 32'd2, 5, 0, 0, 0, 32'd0));
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage plus EX/MEM pipeline register for the 32-bit pipelined RISC core.
- Consumes the 4-bit ALU operation code produced by the ALU control decoder, along with ID/EX operands and control bits.
- Applies forwarding selects from the hazard/forwarding unit, computes the ALU result, zero and overflow flags.
- Registers the result and pass-through control into the EX/MEM stage, with stall and flush support and a retired-operation counter.

## Interface
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, destination register address width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ID/EX slot holds a real instruction
- stall  input  1  hold EX/MEM register contents
- flush  input  1  turn the captured slot into a bubble
- alu_control  input  4  operation: 0 add, 1 sub, 4 and, 5 or
- alu_src  input  1  1 = operand B is imm, 0 = forwarded rt
- rs_data, rt_data  input  DATA_W  register-file read data
- imm  input  DATA_W  sign-extended immediate
- rd_addr  input  REG_ADDR_W  destination register
- reg_write, mem_read, mem_write  input  1  ID/EX control bits
- forward_a, forward_b  input  2  operand select: 00 reg file, 01 MEM/WB, 10 EX/MEM, 11 reg file
- memwb_data  input  DATA_W  write-back value for forwarding
- out_valid  output  1  EX/MEM slot valid
- alu_result  output  DATA_W  registered ALU result; also the EX/MEM forward source
- zero, overflow  output  1  registered flags
- store_data  output  DATA_W  registered forwarded rt value, taken before the alu_src mux
- out_rd_addr  output  REG_ADDR_W  registered destination
- out_reg_write, out_mem_read, out_mem_write  output  1  registered control bits
- op_count  output  32  count of valid instructions captured

## Operation
- Operand A = mux(forward_a): rs_data, memwb_data, alu_result (registered output).
- Forwarded B = mux(forward_b) over the same three sources; operand B = alu_src ? imm : forwarded B.
- ALU results by alu_control code:
  - 0: A+B
  - 1: A−B
  - 4: A&B
  - 5: A|B
  - any other code: result 0, overflow 0
- Arithmetic is modulo 2^DATA_W; no carry output.
- Overflow, add: A and B have the same sign and the result sign differs.
- Overflow, sub: A and B have different signs and the result sign differs from A.
- Overflow is 0 for the logic ops. Overflow is a flag only and never suppresses out_reg_write.
- zero = (result == 0); it is computed for every op, including unused codes (result 0 → zero 1).
- Register update priority per rising edge: flush > stall > capture.
  - flush: out_valid, out_reg_write, out_mem_read, out_mem_write ← 0; data fields hold; op_count unchanged.
  - stall (no flush): all outputs hold.
  - capture with in_valid=1: all fields loaded; out_valid ← 1; op_count increments.
  - capture with in_valid=0: bubble; out_valid and control bits ← 0; data fields loaded; op_count unchanged.
- op_count wraps 0xFFFFFFFF → 0.

## Timing
- Latency: 1 cycle from inputs to registered outputs; ALU and forwarding muxes are purely combinational in between.
- EX/MEM forward path (select 10) uses the current registered alu_result, so back-to-back dependent ops resolve with zero bubbles.
- rst asserted at any time, including mid-stall, clears all outputs to 0 immediately. zero is also reset to 0.
- First capture occurs on the first rising edge after rst deasserts.
- flush and stall asserted together: flush wins.

## Configuration
- EX_FORWARD_EN defined: forwarding muxes as described.
- EX_FORWARD_EN not defined:
  - forward_a, forward_b and memwb_data are present but ignored.
  - A = rs_data; forwarded B = rt_data, which also feeds store_data.
  - All other behaviour is unchanged.

## Structure
- Shared package ex_pkg holds:
  - ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_AND=4'd4, ALU_OR=4'd5
  - FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10
- The ALU control decoder imports the same ALU_* constants.
- One sub-module, alu_core: combinational; inputs A, B, alu_control; outputs result, zero, overflow.
- ex_stage holds the forwarding muxes, the EX/MEM register and op_count.

## Test plan
- Reset mid-operation: rst pulsed while out_valid=1 → all outputs 0 in the same cycle, op_count=0.
- Sub with overflow: A=0x80000000, B=1 via alu_src=0, code 1 → alu_result 0x7FFFFFFF, overflow 1, zero 0.
- Immediate path: code 4, rs=0xF0F0F0F0, alu_src=1, imm=0x0F0F0F0F → alu_result 0, zero 1; store_data = rt_data.
- EX/MEM forwarding: add 3+4 (result 7), then next cycle forward_a=10, rs_data=0, B=1 → alu_result 8.
  - Without EX_FORWARD_EN, the same stimulus gives 1.
- Stall/flush: capture valid op, stall 3 cycles → outputs hold; then flush+stall together → out_valid 0 and controls 0, alu_result held.
- Counter wrap: preload via 2^32−1 valid captures (or force op_count=0xFFFFFFFF) → next valid capture gives 0; bubble captures leave it unchanged.
